// File: rtl/sram_scratchpad_stream.sv
// sram_scratchpad_stream
//   Single-clock scratchpad with two access modes:
//     RANDOM - explicit read/write addresses, pointers and count frozen
//     STREAM - internal circular pointers with full/empty, used as a window buffer
//   Reads are pipelined: a read accepted at edge N drives dout/dout_valid at
//   edge N+RD_LATENCY-1; dout holds its last value between strobes.
//   Optional feature macro: SPAD_WR_BYPASS_EN
//     defined   -> write-first (same-word read sees the incoming din)
//     undefined -> read-first  (same-word read sees the old contents)
module sram_scratchpad_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chip_en,
  input  logic                  mode,
  input  logic                  clear,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic {
    MODE_RANDOM = 1'b0,
    MODE_STREAM = 1'b1
  } mode_e;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH-1:0] wptr_next, rptr_next;
  logic [ADDR_WIDTH:0]   count_next;

  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] waddr_eff, raddr_eff;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [RD_LATENCY-1:0] pipe_v;
  logic [DATA_WIDTH-1:0] pipe_d [RD_LATENCY];

  // Circular pointer advance; wraps at DEPTH-1 even when DEPTH is not a power of two.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // Accept decision and effective addresses for this cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    waddr_eff = waddr;
    raddr_eff = raddr;
    if (mode == MODE_STREAM) begin
      waddr_eff = wptr;
      raddr_eff = rptr;
    end
    // clear overrides any accept in the same cycle.
    if (chip_en && !clear) begin
      if (mode == MODE_STREAM) begin
        // No fall-through: a read on empty is rejected even with a concurrent write.
        rd_acc = ren && !empty;
        wr_acc = wen && (!full || rd_acc);
      end else begin
        rd_acc = ren;
        wr_acc = wen;
      end
    end
  end

  // Out-of-range writes are dropped.
  assign mem_we = wr_acc && ({1'b0, waddr_eff} < DEPTH_W);

  // Read data selection: out-of-range reads return 0; optional write-first bypass.
  always_comb begin
    rd_word = '0;
    if ({1'b0, raddr_eff} < DEPTH_W) begin
      rd_word = mem[raddr_eff];
`ifdef SPAD_WR_BYPASS_EN
      if (wr_acc && (waddr_eff == raddr_eff)) rd_word = din;
`endif
    end
  end

  // Next pointer/occupancy values; only STREAM mode moves them.
  always_comb begin
    wptr_next  = wptr;
    rptr_next  = rptr;
    count_next = count;
    if (clear) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else if (mode == MODE_STREAM) begin
      if (wr_acc) wptr_next = next_ptr(wptr);
      if (rd_acc) rptr_next = next_ptr(rptr);
      if (wr_acc && !rd_acc)      count_next = count + (ADDR_WIDTH + 1)'(1);
      else if (rd_acc && !wr_acc) count_next = count - (ADDR_WIDTH + 1)'(1);
    end
  end

  // Pointer, count and status flag registers (flags follow count on the same edge).
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr_next;
      rptr  <= rptr_next;
      count <= count_next;
      full  <= (count_next == DEPTH_W);
      empty <= (count_next == '0);
    end
  end

  // Storage array; cleared to zero by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the array is reset, so it maps to flops rather than an SRAM macro.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[waddr_eff] <= din;
    end
  end

  // Read pipeline: stage 0 captures at the accepting edge, later stages shift; data holds on bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd_acc;
      if (rd_acc) pipe_d[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign dout       = pipe_d[RD_LATENCY-1];
  assign dout_valid = pipe_v[RD_LATENCY-1];

endmodule

// File: tb/tb_sram_scratchpad_stream.sv
// Self-checking bench for sram_scratchpad_stream (DEPTH=16, RD_LATENCY=2).
// A behavioural model (plain array + ints + queue of due reads) is compared with
// the DUT every negative edge; directed sections pin the model with literal values.
module tb_sram_scratchpad_stream;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          chip_en = 1'b0, mode = 1'b0, clear = 1'b0;
  logic          wen = 1'b0, ren = 1'b0;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid, full, empty;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  sram_scratchpad_stream #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .chip_en(chip_en), .mode(mode), .clear(clear),
    .wen(wen), .waddr(waddr), .din(din), .ren(ren), .raddr(raddr),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_wptr, m_rptr, m_count, cyc;
  rd_t           q[$];
  logic [DW-1:0] last_dout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_wptr = 0; m_rptr = 0; m_count = 0;
      q.delete();
      last_dout = '0;
    end else begin
      bit wa, ra;
      int wad, rad;
      logic [DW-1:0] rdv;
      cyc++;
      wa = 0; ra = 0;
      wad = mode ? m_wptr : int'(waddr);
      rad = mode ? m_rptr : int'(raddr);
      if (chip_en && !clear) begin
        if (mode) begin
          ra = ren && (m_count != 0);
          wa = wen && (m_count != DEPTH || ra);
        end else begin
          ra = ren;
          wa = wen;
        end
      end
      if (ra) begin
        rdv = (rad < DEPTH) ? m_mem[rad] : '0;
`ifdef SPAD_WR_BYPASS_EN
        if (wa && wad == rad && rad < DEPTH) rdv = din;
`endif
        q.push_back('{due: cyc + LAT - 1, data: rdv});
      end
      if (wa && wad < DEPTH) m_mem[wad] = din;
      if (clear) begin
        m_wptr = 0; m_rptr = 0; m_count = 0;
      end else if (mode) begin
        if (wa) m_wptr = (m_wptr + 1) % DEPTH;
        if (ra) m_rptr = (m_rptr + 1) % DEPTH;
        m_count = m_count + int'(wa) - int'(ra);
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic exp_v;
    exp_v = 1'b0;
    if (!rst && q.size() > 0 && q[0].due == cyc) begin
      exp_v     = 1'b1;
      last_dout = q[0].data;
      void'(q.pop_front());
    end
    check("dout_valid", 32'(dout_valid), 32'(exp_v));
    check("dout", 32'(dout), 32'(last_dout));
    check("count", 32'(count), m_count);
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("empty", 32'(empty), 32'(m_count == 0));
  end

  // ---------------- stimulus ----------------
  // Apply inputs for one cycle; returns just after the following negedge.
  task automatic drive(input logic md, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] d, input logic re, input logic [AW-1:0] ra,
                       input logic clr = 1'b0, input logic ce = 1'b1);
    mode = md; wen = we; waddr = wa; din = d; ren = re; raddr = ra;
    clear = clr; chip_en = ce;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic md);
    drive(md, 0, '0, '0, 0, '0);
  endtask

  logic [DW-1:0] exp_word;
  logic          cur_mode;
  int            wbias;

  initial begin
    cyc = 0;
    #1 rst = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(count), 32'd0);
    rst = 1'b0;

    // 1. RANDOM read latency 2
    drive(0, 1, 4'd3, 16'h1234, 0, '0);
    drive(0, 0, '0, '0, 1, 4'd3);              // read accepted at this edge (N)
    check("t1_no_early_valid", 32'(dout_valid), 32'd0);
    idle(0);                                   // edge N+1
    check("t1_valid", 32'(dout_valid), 32'd1);
    check("t1_data", 32'(dout), 32'h1234);
    idle(0);
    check("t1_single_pulse", 32'(dout_valid), 32'd0);
    check("t1_hold", 32'(dout), 32'h1234);

    // 2. STREAM fill / overflow / drain
    drive(1, 0, '0, '0, 0, '0, 1);
    for (int i = 0; i < DEPTH; i++) drive(1, 1, '0, 16'(i), 0, '0);
    check("t2_full", 32'(full), 32'd1);
    check("t2_count16", 32'(count), 32'd16);
    drive(1, 1, '0, 16'hAAAA, 0, '0);
    check("t2_overflow_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, '0, '0, 1, '0);
      if (i > 0) check("t2_order", 32'(dout), i - 1);
    end
    idle(1);
    check("t2_last", 32'(dout), 32'd15);
    check("t2_empty", 32'(empty), 32'd1);

    // 3. STREAM full with simultaneous read and write to the same word
    for (int i = 0; i < DEPTH; i++) drive(1, 1, '0, 16'(16'h100 + i), 0, '0);
    drive(1, 1, '0, 16'hBEEF, 1, '0);
    check("t3_count", 32'(count), 32'd16);
    idle(1);
`ifdef SPAD_WR_BYPASS_EN
    exp_word = 16'hBEEF;
`else
    exp_word = 16'h0100;
`endif
    check("t3_valid", 32'(dout_valid), 32'd1);
    check("t3_bypass", 32'(dout), 32'(exp_word));

    // 4. STREAM empty with simultaneous read and write
    drive(1, 0, '0, '0, 0, '0, 1);
    drive(1, 1, '0, 16'h0055, 1, '0);
    check("t4_count", 32'(count), 32'd1);
    idle(1);
    check("t4_no_valid", 32'(dout_valid), 32'd0);

    // 5. Reset between an accepted read and its dout_valid
    drive(1, 0, '0, '0, 1, '0);
    rst = 1'b1;
    idle(1);
    check("t5_valid", 32'(dout_valid), 32'd0);
    check("t5_dout", 32'(dout), 32'd0);
    check("t5_count", 32'(count), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    idle(1);
    check("t5_valid2", 32'(dout_valid), 32'd0);
    rst = 1'b0;
    drive(0, 0, '0, '0, 1, 4'd0);
    idle(0);
    check("t5_word0_valid", 32'(dout_valid), 32'd1);
    check("t5_word0", 32'(dout), 32'd0);

    // 6. chip_en low, then clear with a write
    drive(1, 0, '0, '0, 0, '0, 1);
    for (int i = 0; i < 3; i++) drive(1, 1, '0, 16'(16'hA0 + i), 0, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, '0, 16'hDEAD, 1, '0, 0, 0);
      check("t6_ce_count", 32'(count), 32'd3);
      check("t6_ce_valid", 32'(dout_valid), 32'd0);
    end
    drive(0, 1, 4'd7, 16'h7777, 0, '0, 0, 0);
    drive(1, 1, '0, 16'h0099, 0, '0, 1);
    check("t6_clear_count", 32'(count), 32'd0);
    check("t6_clear_empty", 32'(empty), 32'd1);
    drive(0, 0, '0, '0, 1, 4'd3);
    drive(0, 0, '0, '0, 1, 4'd1);
    check("t6_w3_dropped", 32'(dout), 32'd0);
    drive(0, 0, '0, '0, 1, 4'd7);
    check("t6_w1", 32'(dout), 32'h00A1);
    idle(0);
    check("t6_ce_write_dropped", 32'(dout), 32'd0);

    // Randomised phase
    cur_mode = 1'b1;
    wbias = 50;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) wbias = $urandom_range(20, 80);
      if ($urandom_range(0, 39) == 0) cur_mode = ~cur_mode;
      rst = ($urandom_range(0, 399) == 0);
      drive(cur_mode,
            $urandom_range(0, 99) < wbias, AW'($urandom), DW'($urandom),
            $urandom_range(0, 99) >= wbias, AW'($urandom),
            $urandom_range(0, 29) == 0, $urandom_range(0, 7) != 0);
    end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) idle(cur_mode);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
